// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
// Build option: MEM_ARBITER_FIXED_PRIO_EN (see mem_arbiter.sv).
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    CPU  = 1'b0,
    HOST = 1'b1
  } requester_e;

  // Picker output is one-hot: bit 0 = CPU, bit 1 = HOST.
  function automatic requester_e onehot_to_req(input logic [1:0] onehot);
    return (onehot == 2'b10) ? HOST : CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, host port and shared memory port around mem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_adr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic [ADDR_W-1:0] mem_adr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  host_req, host_we, host_adr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_adr, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output host_req, host_we, host_adr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_adr, mem_wr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker producing a one-hot winner.
// Build option: MEM_ARBITER_FIXED_PRIO_EN drops the `last` input and gives the CPU priority.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_host,
`ifndef MEM_ARBITER_FIXED_PRIO_EN
  input  requester_e last,
`endif
  output logic [1:0] gnt_onehot
);

  always_comb begin
    // NOTE: default assignment first, so every path drives gnt_onehot and no latch is inferred.
    gnt_onehot = 2'b00;
    if (req_cpu && req_host) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      gnt_onehot = 2'b01;
`else
      // On a tie the side that did not win last time goes first.
      gnt_onehot = (last == CPU) ? 2'b10 : 2'b01;
`endif
    end else if (req_cpu) begin
      gnt_onehot = 2'b01;
    end else if (req_host) begin
      gnt_onehot = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and host requests onto one synchronous 16x8 data-memory port.
// Build option: MEM_ARBITER_FIXED_PRIO_EN = CPU always wins ties (no round-robin state).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk_arb,
  input logic          rst_arb,
  mem_arbiter_if.slave bus
);

  state_e            state;
  requester_e        owner;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
  requester_e        last_q;
`endif

  logic [1:0]        win;
  requester_e        win_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_wdata;

  logic              cpu_gnt_q;
  logic              host_gnt_q;
  logic              cpu_rvalid_q;
  logic              host_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic [ADDR_W-1:0] mem_adr_q;
  logic              mem_wr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  rr_pick2 u_pick (
    .req_cpu    (bus.cpu_req),
    .req_host   (bus.host_req),
`ifndef MEM_ARBITER_FIXED_PRIO_EN
    .last       (last_q),
`endif
    .gnt_onehot (win)
  );

  assign win_id = onehot_to_req(win);

  always_comb begin
    if (win_id == HOST) begin
      sel_we    = bus.host_we;
      sel_adr   = bus.host_adr;
      sel_wdata = bus.host_wdata;
    end else begin
      sel_we    = bus.cpu_we;
      sel_adr   = bus.cpu_adr;
      sel_wdata = bus.cpu_wdata;
    end
  end

  // A reset during an access simply abandons it: every pulse and strobe clears at once.
  always_ff @(posedge clk_arb or posedge rst_arb) begin
    if (rst_arb) begin
      state         <= IDLE;
      owner         <= CPU;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
      last_q        <= HOST;
`endif
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
      mem_adr_q     <= '0;
      mem_wr_q      <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from pre-edge values.
      cpu_gnt_q     <= 1'b0;
      host_gnt_q    <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (|win) begin
            owner       <= win_id;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
            last_q      <= win_id;
`endif
            mem_adr_q   <= sel_adr;
            mem_wr_q    <= sel_we;
            mem_wdata_q <= sel_wdata;
            cpu_gnt_q   <= (win_id == CPU);
            host_gnt_q  <= (win_id == HOST);
            state       <= ACCESS;
          end
        end

        ACCESS: begin
          // Memory acts on this edge; mem_wr_q still says whether it was a write.
          mem_wr_q <= 1'b0;
          state    <= mem_wr_q ? IDLE : RESP;
        end

        RESP: begin
          if (owner == HOST) begin
            host_rdata_q  <= bus.mem_rdata;
            host_rvalid_q <= 1'b1;
          end else begin
            cpu_rdata_q   <= bus.mem_rdata;
            cpu_rvalid_q  <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_gnt     = cpu_gnt_q;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.host_gnt    = host_gnt_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.mem_adr     = mem_adr_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16x8 synchronous memory.
// Expectations follow MEM_ARBITER_FIXED_PRIO_EN when that macro is defined.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic       host;
    logic       we;
    logic [3:0] adr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  logic       clk_arb = 1'b0;
  logic       rst_arb = 1'b1;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_cpu_rd = 8'h00;
  logic [7:0] exp_host_rd = 8'h00;
  logic [7:0] mem [16];
  vec_t       vecs [8];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_arb (clk_arb),
    .rst_arb (rst_arb),
    .bus     (bus)
  );

  always #5 clk_arb = ~clk_arb;

  // Memory contents come back to 0x30+address on every reset.
  always @(posedge clk_arb or posedge rst_arb) begin
    if (rst_arb) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h30 + 8'(i);
      bus.mem_rdata <= 8'h00;
    end else begin
      if (bus.mem_wr) mem[bus.mem_adr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_adr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_arb);
    #1;
  endtask

  task automatic drive_req(input logic host, input logic we, input logic [3:0] adr,
                           input logic [7:0] wd);
    if (host) begin
      bus.host_req = 1'b1; bus.host_we = we; bus.host_adr = adr; bus.host_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_adr = adr; bus.cpu_wdata = wd;
    end
  endtask

  task automatic drop_req(input logic host);
    if (host) bus.host_req = 1'b0;
    else      bus.cpu_req  = 1'b0;
  endtask

  task automatic wait_gnt(input logic host, input string tag, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (host ? bus.host_gnt : bus.cpu_gnt) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check({tag, " gnt_timeout"}, 32'd0, 32'd1);
  endtask

  // Called one step after the grant edge; walks the access to completion.
  task automatic follow(input logic host, input logic we, input logic [3:0] adr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
    check({tag, " other_gnt"}, host ? bus.cpu_gnt : bus.host_gnt, 32'd0);
    check({tag, " mem_wr"}, bus.mem_wr, we);
    check({tag, " mem_adr"}, bus.mem_adr, adr);
    if (we) check({tag, " mem_wdata"}, bus.mem_wdata, wd);
    drop_req(host);
    step();
    check({tag, " gnt_clear"}, bus.cpu_gnt | bus.host_gnt, 32'd0);
    check({tag, " mem_wr_clear"}, bus.mem_wr, 32'd0);
    if (!we) begin
      step();
      if (host) exp_host_rd = exp_rd;
      else      exp_cpu_rd  = exp_rd;
      check({tag, " rvalid"}, host ? bus.host_rvalid : bus.cpu_rvalid, 32'd1);
      check({tag, " other_rvalid"}, host ? bus.cpu_rvalid : bus.host_rvalid, 32'd0);
      check({tag, " cpu_rdata"}, bus.cpu_rdata, exp_cpu_rd);
      check({tag, " host_rdata"}, bus.host_rdata, exp_host_rd);
      step();
      check({tag, " rvalid_clear"}, bus.cpu_rvalid | bus.host_rvalid, 32'd0);
    end
  endtask

  task automatic do_access(input logic host, input logic we, input logic [3:0] adr,
                           input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
    logic ok;
    drive_req(host, we, adr, wd);
    wait_gnt(host, tag, ok);
    if (ok) follow(host, we, adr, wd, exp_rd, tag);
    else    drop_req(host);
  endtask

  // Both requesters raise req in the same cycle; first_host names the expected first winner.
  task automatic tie_pair(input logic first_host,
                          input logic f_we, input logic [3:0] f_adr, input logic [7:0] f_wd,
                          input logic [7:0] f_exp,
                          input logic s_we, input logic [3:0] s_adr, input logic [7:0] s_wd,
                          input logic [7:0] s_exp, input string tag);
    logic any;
    logic ok;
    drive_req(first_host, f_we, f_adr, f_wd);
    drive_req(!first_host, s_we, s_adr, s_wd);
    any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.cpu_gnt | bus.host_gnt) begin
        any = 1'b1;
        break;
      end
      step();
    end
    if (!any) begin
      check({tag, " first_gnt_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " first_winner"}, first_host ? bus.host_gnt : bus.cpu_gnt, 32'd1);
      follow(first_host, f_we, f_adr, f_wd, f_exp, {tag, " first"});
      wait_gnt(!first_host, {tag, " second"}, ok);
      if (ok) follow(!first_host, s_we, s_adr, s_wd, s_exp, {tag, " second"});
    end
    drop_req(1'b0);
    drop_req(1'b1);
  endtask

  initial begin
    logic seen;
    logic exp_host;
    logic ok;
    int   n_gnt;

    //               host  we    adr    wdata  exp_rdata
    vecs[0] = '{1'b1, 1'b1, 4'd5,  8'hA7, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 4'd5,  8'h00, 8'hA7};
    vecs[2] = '{1'b0, 1'b1, 4'd15, 8'h5C, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 8'h00, 8'h5C};
    vecs[4] = '{1'b1, 1'b0, 4'd0,  8'h00, 8'h30};
    vecs[5] = '{1'b0, 1'b0, 4'd9,  8'h00, 8'h39};
    vecs[6] = '{1'b0, 1'b1, 4'd0,  8'hFF, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 4'd0,  8'h00, 8'hFF};

    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_adr = '0;  bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_adr = '0; bus.host_wdata = '0;

    repeat (3) step();
    rst_arb = 1'b0;
    step();

    check("reset cpu_gnt", bus.cpu_gnt, 32'd0);
    check("reset host_gnt", bus.host_gnt, 32'd0);
    check("reset cpu_rvalid", bus.cpu_rvalid, 32'd0);
    check("reset host_rvalid", bus.host_rvalid, 32'd0);
    check("reset mem_wr", bus.mem_wr, 32'd0);
    check("reset mem_adr", bus.mem_adr, 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    check("reset cpu_rdata", bus.cpu_rdata, 32'd0);
    check("reset host_rdata", bus.host_rdata, 32'd0);

    seen = 1'b0;
    repeat (4) begin
      step();
      seen = seen | bus.mem_wr | bus.cpu_gnt | bus.host_gnt | bus.cpu_rvalid | bus.host_rvalid;
    end
    check("idle no_activity", seen, 32'd0);

    // First tie after reset: CPU goes first in both build variants.
    tie_pair(1'b0, 1'b1, 4'd3, 8'h11, 8'h00, 1'b1, 4'd4, 8'h22, 8'h00, "tie_reset");

    // Both requests held: grants alternate (or stay on the CPU with fixed priority).
    drive_req(1'b0, 1'b1, 4'd6, 8'h66);
    drive_req(1'b1, 1'b1, 4'd7, 8'h77);
    n_gnt = 0;
    for (int i = 0; i < 20 && n_gnt < 4; i++) begin
      step();
      if (bus.cpu_gnt | bus.host_gnt) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        exp_host = 1'b0;
`else
        exp_host = n_gnt[0];
`endif
        check($sformatf("held grant%0d host_gnt", n_gnt), bus.host_gnt, exp_host);
        check($sformatf("held grant%0d cpu_gnt", n_gnt), bus.cpu_gnt, !exp_host);
        check($sformatf("held grant%0d mem_adr", n_gnt), bus.mem_adr, exp_host ? 32'd7 : 32'd6);
        n_gnt++;
      end
    end
    drop_req(1'b0);
    drop_req(1'b1);
    check("held grant_count", n_gnt, 32'd4);
    repeat (2) step();

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].host, vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].exp_rdata,
                $sformatf("vec%0d", i));
    end

    // Write and read of one address arriving together: read sees grant order.
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    tie_pair(1'b0, 1'b0, 4'd8, 8'h00, 8'h38, 1'b1, 4'd8, 8'h9D, 8'h00, "wr_rd_8");
    tie_pair(1'b0, 1'b1, 4'd10, 8'h42, 8'h00, 1'b0, 4'd10, 8'h00, 8'h42, "wr_rd_10");
`else
    tie_pair(1'b1, 1'b1, 4'd8, 8'h9D, 8'h00, 1'b0, 4'd8, 8'h00, 8'h9D, "wr_rd_8");
    tie_pair(1'b1, 1'b0, 4'd10, 8'h00, 8'h3A, 1'b1, 4'd10, 8'h42, 8'h00, "wr_rd_10");
`endif

    // Reset while a write strobe is out.
    drive_req(1'b1, 1'b1, 4'd12, 8'h77);
    wait_gnt(1'b1, "rst_wr", ok);
    check("rst_wr mem_wr_before", bus.mem_wr, 32'd1);
    #2;
    rst_arb = 1'b1;
    drop_req(1'b1);
    #1;
    check("rst_wr mem_wr_async", bus.mem_wr, 32'd0);
    check("rst_wr mem_adr", bus.mem_adr, 32'd0);
    step();
    rst_arb = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      step();
      seen = seen | bus.mem_wr | bus.cpu_gnt | bus.host_gnt | bus.cpu_rvalid | bus.host_rvalid;
    end
    check("rst_wr no_activity", seen, 32'd0);

    // Reset between the read-address edge and the data edge.
    drive_req(1'b0, 1'b0, 4'd9, 8'h00);
    wait_gnt(1'b0, "rst_rd", ok);
    drop_req(1'b0);
    step();
    #2;
    rst_arb = 1'b1;
    #1;
    check("rst_rd rvalid_async", bus.cpu_rvalid, 32'd0);
    step();
    rst_arb = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      step();
      seen = seen | bus.cpu_rvalid | bus.host_rvalid | bus.cpu_gnt | bus.host_gnt;
    end
    check("rst_rd no_rvalid", seen, 32'd0);
    check("rst_rd cpu_rdata", bus.cpu_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the shared 16×8 data memory. It sits between the control unit's memory port (LDM/STM traffic) and a host/debug port used to preload or inspect data memory. It serialises the two request streams onto the single synchronous memory port. Round-robin arbitration guarantees neither side starves.

## Interface
Parameters:
- ADDR_W, 4, data memory address width (16 words)
- DATA_W, 8, data word width

Ports:
- clk_arb  in  1  single clock; all state changes on rising edge
- rst_arb  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_gnt is sampled high
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_adr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse; CPU request accepted
- cpu_rdata  out  DATA_W  CPU read data; holds last value
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid
- host_req, host_we, host_adr, host_wdata  in  1/1/ADDR_W/DATA_W  host equivalents of the cpu_* inputs
- host_gnt, host_rdata, host_rvalid  out  1/DATA_W/1  host equivalents of the cpu_* outputs
- mem_adr  out  ADDR_W  memory address, registered
- mem_wr  out  1  memory write strobe, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data; valid one edge after the address edge

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Any request:
    - pick a winner;
    - register its adr/we/wdata onto the mem_* outputs;
    - pulse the winner's gnt;
    - record winner in `last`;
    - go to ACCESS.
- **ACCESS**
  - Memory performs the operation at this edge.
  - Clear mem_wr and gnt.
  - Next state: RESP for a read, IDLE for a write.
- **RESP**
  - Capture mem_rdata into the winner's rdata register.
  - Pulse the winner's rvalid.
  - Go to IDLE.
- **Winner selection**
  - Only one req high: that requester wins.
  - Both high: the requester that is not `last` wins.
  - The loser keeps req high and is served on the next IDLE.
- Read data for the non-winning requester is never modified.
- mem_adr and mem_wdata hold their values after an access.
- The registered strobe pulses mem_wr for one cycle per write.
- Reset values:
  - state = IDLE;
  - `last` = HOST, so the CPU wins the first tie;
  - all gnt, rvalid and mem_wr = 0;
  - mem_adr, mem_wdata, cpu_rdata, host_rdata = 0.
- **Reset mid-operation**
  - The in-flight access is abandoned.
  - mem_wr drops asynchronously.
  - No gnt or rvalid is issued after reset release for the abandoned request.
  - The requester must re-issue it.

## Timing
- Requester rule: drop req (or present a new request) on the edge where gnt is sampled high.
  - req still high after gnt is treated as a new request.
- Edge numbering for one access:
  - E0: request sampled in IDLE.
  - gnt and mem_* are high/valid between E0 and E1.
  - E1: memory write or read-address capture.
  - E2: read data registered; rvalid high between E2 and E3.
- Read latency: rvalid is high 2 edges after acceptance.
- Write: occupies 2 edges (IDLE→ACCESS→IDLE).
- Throughput:
  - back-to-back writes: one every 2 cycles;
  - back-to-back reads: one every 3 cycles.
- Simultaneous requests: serviced in alternation. Worst-case wait is one foreign access, i.e. 3 cycles.
- Address width rule: no wrap logic; addresses are taken modulo 2^ADDR_W.

## Configuration
- MEM_ARBITER_FIXED_PRIO_EN
  - Defined: the CPU always wins ties and `last` is not implemented. The host can starve while the CPU requests continuously.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - requester enum (CPU, HOST);
  - ADDR_W/DATA_W defaults.
- One sub-module, rr_pick2: combinational 2-way round-robin picker.
  - Inputs: two reqs and `last`.
  - Outputs: one-hot winner.
  - Under MEM_ARBITER_FIXED_PRIO_EN it reduces to CPU priority.

## Test plan
- Reset, then idle: all outputs 0, no mem_wr.
  - Assert rst_arb mid-access: mem_wr is 0 immediately and no rvalid follows.
- Host write: host_req, we=1, adr=5, wdata=0xA7 → host_gnt pulse; mem_wr=1 with mem_adr=5, mem_wdata=0xA7 for one cycle.
- CPU read of adr=5 afterwards: cpu_rvalid pulses 2 edges after cpu_gnt with cpu_rdata=0xA7; host_rdata unchanged.
- Both req in the same cycle from reset: CPU is granted first, host next.
  - Repeat with both requests held continuously: grants strictly alternate CPU, HOST, CPU, HOST.
- Write-then-read to the same address from different requesters, arriving together: accesses are serialised in grant order, and the read returns the value per that order.
- With MEM_ARBITER_FIXED_PRIO_EN and both held high: only cpu_gnt pulses and host_gnt stays 0.
